// File: rtl/reaction_pkg.sv
// Shared types and default constants for the reaction-timer sequencing controller.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        REACT = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam int unsigned SEC_DIV_DEF = 50000000;
    localparam int unsigned MS_DIV_DEF  = 50000;
    localparam int unsigned MAX_MS_DEF  = 999;

    // Width of a counter that must hold 0 .. div-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/reaction_ctrl_tick_gen.sv
// Restartable prescaler: emits a 1-cycle tick every DIV clocks, the first one
// DIV clocks after the edge on which restart was sampled.
module tick_gen
    import reaction_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic restart,
    output logic tick
);

    localparam int unsigned     CW   = cnt_width(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded from the register alone so the FSM's restart request never
    // feeds back into the tick it consumes.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: arm on start, wait delay_sec seconds, light the LED
// and time the response in ms. Optional best-time register under REACTION_BEST_EN.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned SEC_DIV  = SEC_DIV_DEF,
    parameter int unsigned MS_DIV   = MS_DIV_DEF,
    parameter int unsigned DELAY_W  = 8,
    parameter int unsigned RESULT_W = 10,
    parameter int unsigned MAX_MS   = MAX_MS_DEF
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                start,
    input  logic                resp,
    input  logic [DELAY_W-1:0]  delay_sec,
    output logic                led,
    output logic [RESULT_W-1:0] result,
    output logic                result_valid,
    output logic                false_start,
    output logic                timeout,
    output logic                busy,
    output logic [RESULT_W-1:0] best_ms
);

    localparam logic [RESULT_W-1:0] MS_LAST = RESULT_W'(MAX_MS - 1);
    localparam logic [RESULT_W-1:0] MS_MAX  = RESULT_W'(MAX_MS);

    state_t               state_q, state_d;
    logic                 start_q, resp_q;
    logic                 start_p_q, resp_p_q;
    logic                 start_rise, resp_rise;
    logic [DELAY_W-1:0]   dly_q, dly_d;
    logic [DELAY_W-1:0]   sec_cnt_q, sec_cnt_d, sec_next;
    logic [RESULT_W-1:0]  ms_cnt_q, ms_cnt_d;
    logic [RESULT_W-1:0]  result_q, result_d;
    logic                 result_valid_q, result_valid_d;
    logic                 false_start_q, false_start_d;
    logic                 timeout_q, timeout_d;
    logic                 led_q, led_d;
    logic                 busy_q, busy_d;
    logic                 sec_tick, ms_tick;
    logic                 sec_restart, ms_restart;

    // Edges are registered into pulses so every response is one clock behind
    // its sample, matching the registered-output latency of the old glue.
    assign start_rise = start & ~start_q;
    assign resp_rise  = resp & ~resp_q;

    assign sec_restart = (state_d == WAIT)  && (state_q != WAIT);
    assign ms_restart  = (state_d == REACT) && (state_q != REACT);

    tick_gen #(.DIV(SEC_DIV)) u_sec_tick (
        .clk     (clk),
        .clear   (clear),
        .restart (sec_restart),
        .tick    (sec_tick)
    );

    tick_gen #(.DIV(MS_DIV)) u_ms_tick (
        .clk     (clk),
        .clear   (clear),
        .restart (ms_restart),
        .tick    (ms_tick)
    );

    always_comb begin
        state_d        = state_q;
        dly_d          = dly_q;
        sec_cnt_d      = sec_cnt_q;
        ms_cnt_d       = ms_cnt_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        false_start_d  = false_start_q;
        timeout_d      = timeout_q;
        sec_next       = sec_cnt_q + DELAY_W'(1);

        case (state_q)
            IDLE, DONE, FAULT: begin
                if (start_p_q) begin
                    state_d        = WAIT;
                    dly_d          = (delay_sec == '0) ? DELAY_W'(1) : delay_sec;
                    sec_cnt_d      = '0;
                    ms_cnt_d       = '0;
                    result_valid_d = 1'b0;
                    false_start_d  = 1'b0;
                    timeout_d      = 1'b0;
                end
            end
            WAIT: begin
                if (resp_p_q) begin
                    state_d       = FAULT;
                    false_start_d = 1'b1;
                end else if (sec_tick) begin
                    sec_cnt_d = sec_next;
                    if (sec_next == dly_q) begin
                        state_d = REACT;
                    end
                end
            end
            REACT: begin
                // A response in the same cycle as the final tick still counts.
                if (resp_p_q) begin
                    state_d        = DONE;
                    result_d       = ms_cnt_q;
                    result_valid_d = 1'b1;
                end else if (ms_tick) begin
                    if (ms_cnt_q == MS_LAST) begin
                        state_d   = FAULT;
                        timeout_d = 1'b1;
                        result_d  = MS_MAX;
                    end else begin
                        ms_cnt_d = ms_cnt_q + RESULT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        led_d  = (state_d == REACT);
        busy_d = (state_d == WAIT) || (state_d == REACT);
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            start_q        <= 1'b1;
            resp_q         <= 1'b1;
            start_p_q      <= 1'b0;
            resp_p_q       <= 1'b0;
            state_q        <= IDLE;
            dly_q          <= '0;
            sec_cnt_q      <= '0;
            ms_cnt_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            timeout_q      <= 1'b0;
            led_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            start_q        <= start;
            resp_q         <= resp;
            start_p_q      <= start_rise;
            resp_p_q       <= resp_rise;
            state_q        <= state_d;
            dly_q          <= dly_d;
            sec_cnt_q      <= sec_cnt_d;
            ms_cnt_q       <= ms_cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            false_start_q  <= false_start_d;
            timeout_q      <= timeout_d;
            led_q          <= led_d;
            busy_q         <= busy_d;
        end
    end

`ifdef REACTION_BEST_EN
    logic [RESULT_W-1:0] best_q, best_d;

    always_comb begin
        best_d = best_q;
        if ((state_q == REACT) && (state_d == DONE) && (result_d < best_q)) begin
            best_d = result_d;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            best_q <= '1;
        end else begin
            best_q <= best_d;
        end
    end

    assign best_ms = best_q;
`else
    assign best_ms = '1;
`endif

    assign led          = led_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign false_start  = false_start_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: directed trials plus randomized trials checked
// against an edge-count model of the trial timeline.
module tb_reaction_ctrl;

    localparam int SEC_DIV  = 10;
    localparam int MS_DIV   = 4;
    localparam int MAX_MS   = 20;
    localparam int DELAY_W  = 8;
    localparam int RESULT_W = 10;
    localparam int TO_CYC   = MAX_MS * MS_DIV;
    localparam int ALL1     = (1 << RESULT_W) - 1;

    logic                clk = 1'b0;
    logic                clear;
    logic                start;
    logic                resp;
    logic [DELAY_W-1:0]  delay_sec;
    logic                led;
    logic [RESULT_W-1:0] result;
    logic                result_valid;
    logic                false_start;
    logic                timeout;
    logic                busy;
    logic [RESULT_W-1:0] best_ms;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int exp_result = 0;
    int exp_best   = ALL1;

    always #5 clk = ~clk;

    reaction_ctrl #(
        .SEC_DIV  (SEC_DIV),
        .MS_DIV   (MS_DIV),
        .DELAY_W  (DELAY_W),
        .RESULT_W (RESULT_W),
        .MAX_MS   (MAX_MS)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .start        (start),
        .resp         (resp),
        .delay_sec    (delay_sec),
        .led          (led),
        .result       (result),
        .result_valid (result_valid),
        .false_start  (false_start),
        .timeout      (timeout),
        .busy         (busy),
        .best_ms      (best_ms)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_led"},   32'(led),          32'(0));
        chk({tag, "_res"},   32'(result),       32'(0));
        chk({tag, "_rv"},    32'(result_valid), 32'(0));
        chk({tag, "_fs"},    32'(false_start),  32'(0));
        chk({tag, "_to"},    32'(timeout),      32'(0));
        chk({tag, "_busy"},  32'(busy),         32'(0));
        chk({tag, "_best"},  32'(best_ms),      32'(ALL1));
    endtask

    // One trial. rsp_s is the response sample edge relative to the start
    // sample edge (negative: no response). kind: 0 done, 1 false start, 2 timeout.
    task automatic run_trial(input int d, input int rsp_s, input bit glitch, input bit hold);
        int s, led_e, t, end_e, kind, new_res, new_best;
        bit fin;
        delay_sec = DELAY_W'(d);
        start = 1'b1;
        resp  = hold;
        step();
        s = cyc;
        start = 1'b0;
        chk("busy_at_start", 32'(busy), 32'(0));
        led_e = s + ((d == 0) ? 1 : d) * SEC_DIV + 1;
        t = (rsp_s < 0) ? -1 : s + rsp_s;
        if (t >= 0 && t < led_e) begin
            kind = 1; end_e = t + 1; new_res = exp_result;
        end else if (t >= 0 && t + 1 <= led_e + TO_CYC) begin
            kind = 0; end_e = t + 1; new_res = (t - led_e) / MS_DIV;
        end else begin
            kind = 2; end_e = led_e + TO_CYC; new_res = MAX_MS;
        end
        new_best = exp_best;
`ifdef REACTION_BEST_EN
        if (kind == 0 && new_res < exp_best) new_best = new_res;
`endif
        while (cyc < end_e + 2) begin
            start = glitch && (cyc + 1 == s + 2);
            resp  = hold || (cyc + 1 == t);
            step();
            fin = (cyc >= end_e);
            chk("led",  32'(led),  32'((cyc >= led_e) && !fin));
            chk("busy", 32'(busy), 32'(!fin));
            chk("result",       32'(result),       32'(fin ? new_res : exp_result));
            chk("result_valid", 32'(result_valid), 32'(fin && kind == 0));
            chk("false_start",  32'(false_start),  32'(fin && kind == 1));
            chk("timeout",      32'(timeout),      32'(fin && kind == 2));
            chk("best_ms",      32'(best_ms),      32'(fin ? new_best : exp_best));
        end
        start = 1'b0;
        exp_result = new_res;
        exp_best   = new_best;
        $display("trial d=%0d start@%0d led@%0d end@%0d kind=%0d result=%0d best=%0d",
                 d, s, led_e, end_e, kind, new_res, new_best);
    endtask

    initial begin
        int d, lat, k, rsp;
        bit gl;
        clear = 1'b0;
        start = 1'b0;
        resp  = 1'b0;
        delay_sec = '0;
        repeat (3) step();
        check_reset_vals("reset");
        clear = 1'b1;
        step();

        // Directed: normal, false start, timeout, resp-wins-on-final-tick.
        run_trial(2, 21 + 30, 1'b0, 1'b0);
        run_trial(3, 5, 1'b0, 1'b0);
        run_trial(1, -1, 1'b0, 1'b0);
        run_trial(1, 11 + TO_CYC - 1, 1'b1, 1'b0);

        // Mid-trial abort with resp held high across the release of clear.
        delay_sec = DELAY_W'(1);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (15) step();
        chk("led_before_abort", 32'(led), 32'(1));
        resp = 1'b1;
        #1 clear = 1'b0;
        #1;
        check_reset_vals("abort");
        step();
        step();
        clear = 1'b1;
        exp_result = 0;
        exp_best   = ALL1;
        step();
        $display("abort: clear pulsed during REACT, resp held high through release");
        run_trial(0, -1, 1'b0, 1'b1);
        resp = 1'b0;
        step();

        // Best-time sequence 9, 5, 12.
        run_trial(1, 11 + 9 * MS_DIV, 1'b0, 1'b0);
        run_trial(1, 11 + 5 * MS_DIV, 1'b0, 1'b0);
        run_trial(1, 11 + 12 * MS_DIV, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            d   = int'($urandom_range(0, 3));
            lat = ((d == 0) ? 1 : d) * SEC_DIV + 1;
            k   = int'($urandom_range(0, 2));
            if (k == 0)      rsp = int'($urandom_range(1, lat - 1));
            else if (k == 1) rsp = int'($urandom_range(lat, lat + TO_CYC - 1));
            else             rsp = -1;
            gl = (k != 0) && ($urandom_range(0, 1) == 1);
            run_trial(d, rsp, gl, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
